// File: rtl/dpram_linebuf.sv
// rtl/dpram_linebuf.sv - byte-enabled line buffer with fill port, per-byte dirty tracking and flush sequencer
module dpram_linebuf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     a_addr,
    input  logic [DATA_WIDTH/8-1:0]   a_we,
    input  logic [DATA_WIDTH-1:0]     a_di,
    output logic [DATA_WIDTH-1:0]     a_do,
    input  logic                      f_we,
    input  logic [ADDR_WIDTH-1:0]     f_addr,
    input  logic [DATA_WIDTH-1:0]     f_di,
    input  logic                      flush_req,
    output logic                      busy,
    output logic                      flush_done,
    output logic                      fl_valid,
    input  logic                      fl_ready,
    output logic [ADDR_WIDTH-1:0]     fl_addr,
    output logic [DATA_WIDTH-1:0]     fl_data,
    output logic [DATA_WIDTH/8-1:0]   fl_mask
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_READ,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [ADDR_WIDTH-1:0]   w_idx_nxt;

    logic [DATA_WIDTH-1:0]   r_mem   [DEPTH];
    logic [BYTES-1:0]        r_dirty [DEPTH];
    logic [BYTES-1:0]        w_dirty_nxt [DEPTH];

    logic [DATA_WIDTH-1:0]   r_do;
    logic [ADDR_WIDTH-1:0]   r_fl_addr;
    logic [DATA_WIDTH-1:0]   r_fl_data;
    logic [BYTES-1:0]        r_fl_mask;

    logic                    w_fill_en;
    logic                    w_accept;
    logic                    w_idx_last;
    logic                    w_idx_dirty;
    logic                    w_a_hits_idx;
    logic [DATA_WIDTH-1:0]   w_a_word;
    logic [DATA_WIDTH-1:0]   w_rd_word;
    logic [BYTES-1:0]        w_rd_mask;

    // Fills are only accepted while the sequencer is idle.
    assign w_fill_en    = f_we && (r_state == S_IDLE);
    assign w_accept     = (r_state == S_PRESENT) && fl_ready;
    assign w_idx_last   = (r_idx == {ADDR_WIDTH{1'b1}});
    assign w_idx_dirty  = |r_dirty[r_idx];
    assign w_a_hits_idx = (a_addr == r_idx);

    // Post-write word at a_addr: fill data first, host bytes on top.
    always_comb begin
        w_a_word = (w_fill_en && (f_addr == a_addr)) ? f_di : r_mem[a_addr];
        for (int b = 0; b < BYTES; b++) begin
            if (a_we[b]) begin
                w_a_word[8*b +: 8] = a_di[8*b +: 8];
            end
        end
    end

    // Capture for the flush view includes a host write landing in the READ cycle.
    always_comb begin
        w_rd_word = r_mem[r_idx];
        w_rd_mask = r_dirty[r_idx];
        if (w_a_hits_idx) begin
            w_rd_mask = r_dirty[r_idx] | a_we;
            for (int b = 0; b < BYTES; b++) begin
                if (a_we[b]) begin
                    w_rd_word[8*b +: 8] = a_di[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill_en) begin
            r_mem[f_addr] <= f_di;
        end
        if (|a_we) begin
            r_mem[a_addr] <= w_a_word;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_dirty_nxt[i] = r_dirty[i];
            if (w_fill_en && (f_addr == ADDR_WIDTH'(i))) begin
                w_dirty_nxt[i] = '0;
            end
            if (w_accept && (r_idx == ADDR_WIDTH'(i))) begin
                w_dirty_nxt[i] = w_dirty_nxt[i] & ~r_fl_mask;
            end
            if (a_addr == ADDR_WIDTH'(i)) begin
                w_dirty_nxt[i] = w_dirty_nxt[i] | a_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                r_dirty[i] <= '0;
            end else begin
                r_dirty[i] <= w_dirty_nxt[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (flush_req) begin
                    w_state_nxt = S_SCAN;
                    w_idx_nxt   = '0;
                end
            end
            S_SCAN: begin
                if (w_idx_dirty) begin
                    w_state_nxt = S_READ;
                end else if (w_idx_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_READ: begin
                w_state_nxt = S_PRESENT;
            end
            S_PRESENT: begin
                if (fl_ready) begin
                    if (w_idx_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_SCAN;
                        w_idx_nxt   = r_idx + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_do      <= '0;
            r_fl_addr <= '0;
            r_fl_data <= '0;
            r_fl_mask <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_do    <= w_a_word;
            if (r_state == S_READ) begin
                r_fl_addr <= r_idx;
                r_fl_data <= w_rd_word;
                r_fl_mask <= w_rd_mask;
            end
        end
    end

    assign a_do       = r_do;
    assign busy       = (r_state != S_IDLE);
    assign flush_done = (r_state == S_DONE);
    assign fl_valid   = (r_state == S_PRESENT);
    assign fl_addr    = r_fl_addr;
    assign fl_data    = r_fl_data;
    assign fl_mask    = r_fl_mask;

endmodule

// File: tb/tb_dpram_linebuf.sv
// tb/tb_dpram_linebuf.sv - scoreboard bench for dpram_linebuf
module tb_dpram_linebuf;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  a_addr = '0;
    logic [3:0]  a_we = '0;
    logic [31:0] a_di = '0;
    logic [31:0] a_do;
    logic        f_we = 1'b0;
    logic [2:0]  f_addr = '0;
    logic [31:0] f_di = '0;
    logic        flush_req = 1'b0;
    logic        busy;
    logic        flush_done;
    logic        fl_valid;
    logic        fl_ready = 1'b0;
    logic [2:0]  fl_addr;
    logic [31:0] fl_data;
    logic [3:0]  fl_mask;

    dpram_linebuf #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .a_addr(a_addr), .a_we(a_we), .a_di(a_di), .a_do(a_do),
        .f_we(f_we), .f_addr(f_addr), .f_di(f_di),
        .flush_req(flush_req), .busy(busy), .flush_done(flush_done),
        .fl_valid(fl_valid), .fl_ready(fl_ready),
        .fl_addr(fl_addr), .fl_data(fl_data), .fl_mask(fl_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } fl_t;

    logic [31:0] rd_q [$];
    fl_t         fl_q [$];
    int          done_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        rd_req = 1'b0;
    logic        rd_req_d = 1'b0;
    logic        hold_prev = 1'b0;
    logic [2:0]  p_addr;
    logic [31:0] p_data;
    logic [3:0]  p_mask;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_req_d <= rd_req;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Monitor: host reads, flush transfers, hold stability, done pulses.
    always @(negedge clk) begin
        logic [31:0] er;
        fl_t         ef;
        int          ed;
        if (rd_req_d) begin
            if (rd_q.size() == 0) fail("rd_q underflow");
            else begin
                er = rd_q.pop_front();
                chk("a_do", a_do, er);
            end
        end
        if (hold_prev) begin
            chk("hold_valid", fl_valid, 1);
            chk("hold_addr", fl_addr, p_addr);
            chk("hold_data", fl_data, p_data);
            chk("hold_mask", fl_mask, p_mask);
        end
        if (fl_valid && fl_ready) begin
            if (fl_q.size() == 0) fail("unexpected flush transfer");
            else begin
                ef = fl_q.pop_front();
                chk("fl_addr", fl_addr, ef.addr);
                chk("fl_data", fl_data, ef.data);
                chk("fl_mask", fl_mask, ef.mask);
            end
        end
        if (flush_done) begin
            if (done_q.size() == 0) fail("unexpected flush_done");
            else begin
                ed = done_q.pop_front();
                chk("done_cycle", cyc, ed);
                chk("fl_q_empty_at_done", fl_q.size(), 0);
                chk("busy_at_done", busy, 1);
            end
        end
        hold_prev = fl_valid && !fl_ready && !rst;
        p_addr    = fl_addr;
        p_data    = fl_data;
        p_mask    = fl_mask;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [2:0] ad, input logic [3:0] we, input logic [31:0] di);
        a_addr = ad; a_we = we; a_di = di;
        step();
        a_we = '0;
    endtask

    task automatic fill(input logic [2:0] ad, input logic [31:0] di);
        f_we = 1'b1; f_addr = ad; f_di = di;
        step();
        f_we = 1'b0;
    endtask

    task automatic host_read(input logic [2:0] ad, input logic [31:0] exp);
        a_addr = ad; rd_req = 1'b1;
        rd_q.push_back(exp);
        step();
        rd_req = 1'b0;
    endtask

    task automatic start_flush(input int off);
        flush_req = 1'b1;
        if (off > 0) done_q.push_back(cyc + off);
        step();
        flush_req = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 60; k++) begin
            if (done_q.size() == 0 && !busy) break;
            step();
        end
        if (k == 60) fail("wait_idle timeout");
    endtask

    initial begin
        step();
        step();
        chk("rst_a_do", a_do, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_fl_valid", fl_valid, 0);
        chk("rst_fl_addr", fl_addr, 0);
        chk("rst_fl_data", fl_data, 0);
        chk("rst_fl_mask", fl_mask, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) fill(3'(i), 32'h1000_0000 + i);
        for (int i = 0; i < 8; i++) host_read(3'(i), 32'h1000_0000 + i);
        step();
        start_flush(9);
        wait_idle();

        fill(3'd2, 32'hAABB_CCDD);
        host_write(3'd2, 4'b0101, 32'h1122_3344);
        fl_ready = 1'b1;
        fl_q.push_back('{addr: 3'd2, data: 32'hAA22_CC44, mask: 4'b0101});
        start_flush(11);
        wait_idle();
        host_read(3'd2, 32'hAA22_CC44);

        host_write(3'd0, 4'b1111, 32'hA0A0_A0A0);
        host_write(3'd7, 4'b1100, 32'h7777_0000);
        fl_ready = 1'b0;
        fl_q.push_back('{addr: 3'd0, data: 32'hA0A0_A0A0, mask: 4'b1111});
        fl_q.push_back('{addr: 3'd7, data: 32'h7777_0007, mask: 4'b1100});
        start_flush(18);
        repeat (7) step();
        fl_ready = 1'b1;
        wait_idle();
        start_flush(9);
        wait_idle();

        host_write(3'd3, 4'b0010, 32'h0000_5500);
        fl_ready = 1'b0;
        fl_q.push_back('{addr: 3'd3, data: 32'h1000_5503, mask: 4'b0010});
        start_flush(11);
        repeat (5) step();
        a_addr = 3'd3; a_we = 4'b0001; a_di = 32'h0000_00EE; fl_ready = 1'b1;
        step();
        a_we = '0;
        wait_idle();
        fl_q.push_back('{addr: 3'd3, data: 32'h1000_55EE, mask: 4'b0001});
        start_flush(11);
        wait_idle();

        f_we = 1'b1; f_addr = 3'd5; f_di = 32'h0102_0304;
        a_addr = 3'd5; a_we = 4'b1000; a_di = 32'hEE00_0000;
        rd_req = 1'b1;
        rd_q.push_back(32'hEE02_0304);
        step();
        f_we = 1'b0; a_we = '0; rd_req = 1'b0;
        host_read(3'd5, 32'hEE02_0304);
        fl_q.push_back('{addr: 3'd5, data: 32'hEE02_0304, mask: 4'b1000});
        start_flush(11);
        fill(3'd5, 32'hDEAD_BEEF);
        wait_idle();
        host_read(3'd5, 32'hEE02_0304);

        host_write(3'd1, 4'b1111, 32'h1234_5678);
        fl_ready = 1'b0;
        start_flush(0);
        repeat (3) step();
        chk("pre_rst_fl_valid", fl_valid, 1);
        rst = 1'b1;
        step();
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_fl_valid", fl_valid, 0);
        rst = 1'b0;
        repeat (12) step();
        fl_ready = 1'b1;
        start_flush(9);
        wait_idle();

        step();
        chk("rd_q_drained", rd_q.size(), 0);
        chk("fl_q_drained", fl_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end
endmodule
